// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
// Op codes, FSM states and the iteration count.
package muldiv_pkg;

  localparam int MD_ITER = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX
  } state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiplier / restoring divider with sign correction.
// Sequenced by load/step/fix strobes from the HI/LO controller.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         load,
  input  logic         step,
  input  logic         fix,
  input  logic         is_div,
  input  logic         is_sgn,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res_hi,
  output logic [W-1:0] res_lo
);

  logic [2*W-1:0] acc;
  logic [W-1:0]   opb;
  logic [W:0]     rem;
  logic           sa, sb, div_q, bz;

  logic           a_neg, b_neg;
  logic [W-1:0]   abs_a, abs_b;
  logic [W:0]     madd, rem_sh, diff;
  logic [W-1:0]   quo, rmd;
  logic [2*W-1:0] prod;

  assign a_neg  = is_sgn & a[W-1];
  assign b_neg  = is_sgn & b[W-1];
  assign abs_a  = a_neg ? -a : a;
  assign abs_b  = b_neg ? -b : b;

  assign madd   = {1'b0, acc[2*W-1:W]}
                + (acc[0] ? {1'b0, opb} : '0);
  assign rem_sh = {rem[W-1:0], acc[W-1]};
  assign diff   = rem_sh - {1'b0, opb};

  always_ff @(posedge clk) begin
    if (load) begin
      div_q <= is_div;
      sa    <= a_neg;
      sb    <= b_neg;
      bz    <= (b == '0);
      acc   <= {{W{1'b0}}, abs_a};
      opb   <= abs_b;
      rem   <= '0;
    end else if (step) begin
      if (div_q) begin
        rem <= diff[W] ? rem_sh : diff;
        acc <= {acc[2*W-1:W], acc[W-2:0], ~diff[W]};
      end else begin
        acc <= {madd, acc[W-1:1]};
      end
    end
  end

  // Divide by zero keeps the all-ones quotient and the dividend remainder.
  assign quo  = bz ? '1 : ((sa ^ sb) ? -acc[W-1:0] : acc[W-1:0]);
  assign rmd  = sa ? -rem[W-1:0] : rem[W-1:0];
  assign prod = (sa ^ sb) ? -acc : acc;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    if (fix) begin
      if (div_q) begin
        res_hi = rmd;
        res_lo = quo;
      end else begin
        res_hi = prod[2*W-1:W];
        res_lo = prod[W-1:0];
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// HI/LO owner for the EX stage: sequences iterative mul/div,
// services MTHI/MTLO and stalls HI/LO consumers while busy.
module hilo_muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = MD_ITER
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Abort,
  input  logic             HiLoRead,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             Stall
);

  localparam int CW = $clog2(ITER);

  state_e           state;
  logic [CW-1:0]    cnt;
  logic             md_op, op_ok;
  logic             load, step, fix;
  logic             is_div, is_sgn;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign md_op  = ~Op[2];
  assign op_ok  = md_op | (Op == OP_MTHI) | (Op == OP_MTLO);
  assign is_div = (Op == OP_DIV) | (Op == OP_DIVU);
  assign is_sgn = (Op == OP_MULT) | (Op == OP_DIV);

  assign load = (state == ST_IDLE) & Start & ~Abort & md_op;
  assign step = (state == ST_CALC) & ~Abort;
  assign fix  = (state == ST_FIX) & ~Abort;

  assign Stall = Busy & ((Start & op_ok) | HiLoRead);

  muldiv_datapath #(.W(WIDTH)) u_dp (
    .clk    (Clk),
    .load   (load),
    .step   (step),
    .fix    (fix),
    .is_div (is_div),
    .is_sgn (is_sgn),
    .a      (A),
    .b      (B),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      Hi    <= '0;
      Lo    <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (Start & ~Abort) begin
            if (Op == OP_MTHI) Hi <= A;
            if (Op == OP_MTLO) Lo <= A;
            if (md_op) begin
              state <= ST_CALC;
              cnt   <= '0;
              Busy  <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          if (Abort) begin
            state <= ST_IDLE;
            Busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(ITER - 1)) state <= ST_FIX;
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
          if (~Abort) begin
            Hi   <= res_hi;
            Lo   <= res_lo;
            Done <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Randomized bench for hilo_muldiv_sequencer against an
// arithmetic reference model of HI/LO results and timing.
module tb_hilo_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset, Start, Abort, HiLoRead;
  logic [2:0]  Op;
  logic [31:0] A, B, Hi, Lo;
  logic        Busy, Done, Stall;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 Clk = ~Clk;

  hilo_muldiv_sequencer dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Op       (Op),
    .A        (A),
    .B        (B),
    .Abort    (Abort),
    .HiLoRead (HiLoRead),
    .Hi       (Hi),
    .Lo       (Lo),
    .Busy     (Busy),
    .Done     (Done),
    .Stall    (Stall)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ref_md(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] hi,
                        output logic [31:0] lo);
    longint      sp;
    logic [63:0] p;
    int          q, r;
    hi = '0;
    lo = '0;
    case (op)
      3'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        p  = sp;
        hi = p[63:32];
        lo = p[31:0];
      end
      3'd1: begin
        p  = {32'd0, a} * {32'd0, b};
        hi = p[63:32];
        lo = p[31:0];
      end
      3'd2: begin
        if (b == 0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          hi = 0;
          lo = 32'h8000_0000;
        end else begin
          q  = $signed(a) / $signed(b);
          r  = $signed(a) % $signed(b);
          hi = r;
          lo = q;
        end
      end
      default: begin
        if (b == 0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else begin
          hi = a % b;
          lo = a / b;
        end
      end
    endcase
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called mid low phase; returns mid low phase of the Done cycle.
  task automatic run_md(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int rd_at,
                        input int st2_at);
    logic [31:0] rh, rl;
    int k = 0;
    int bad_busy = 0, bad_hold = 0, bad_stall = 0;
    ref_md(op, a, b, rh, rl);
    Start = 1; Op = op; A = a; B = b; Abort = 0; HiLoRead = 0;
    #1 chk("stall_accept", Stall, 0);
    @(negedge Clk);
    Start = 0;
    while (k < 100) begin
      HiLoRead = (rd_at >= 0 && k >= rd_at);
      if (k == st2_at) begin
        Start = 1; Op = OP_MULT; A = $urandom; B = $urandom;
      end
      #1;
      if (Done) break;
      if (Busy !== 1'b1) bad_busy++;
      if (Hi !== exp_hi || Lo !== exp_lo) bad_hold++;
      if (Stall !== (HiLoRead | Start)) bad_stall++;
      @(negedge Clk);
      Start = 0;
      k++;
    end
    chk("latency", k, 33);
    chk("busy_seq", bad_busy, 0);
    chk("hilo_hold", bad_hold, 0);
    chk("stall_seq", bad_stall, 0);
    chk("hi", Hi, rh);
    chk("lo", Lo, rl);
    chk("busy_done", Busy, 0);
    chk("stall_done", Stall, 0);
    exp_hi = rh;
    exp_lo = rl;
    HiLoRead = 0;
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] a);
    Start = 1; Op = op; A = a;
    @(negedge Clk);
    Start = 0;
    #1;
    if (op == OP_MTHI) exp_hi = a;
    else exp_lo = a;
    chk("mt_hi", Hi, exp_hi);
    chk("mt_lo", Lo, exp_lo);
    chk("mt_busy", Busy, 0);
  endtask

  task automatic cut(input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input int at,
                     input bit use_rst);
    int bad = 0;
    Start = 1; Op = op; A = a; B = b;
    @(negedge Clk);
    Start = 0;
    for (int k = 0; k < at; k++) @(negedge Clk);
    if (use_rst) Reset = 1;
    else Abort = 1;
    @(negedge Clk);
    Reset = 0;
    Abort = 0;
    #1;
    if (use_rst) begin
      exp_hi = '0;
      exp_lo = '0;
    end
    chk("cut_busy", Busy, 0);
    chk("cut_done", Done, 0);
    chk("cut_hi", Hi, exp_hi);
    chk("cut_lo", Lo, exp_lo);
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      #1;
      if (Done || Busy || Hi !== exp_hi || Lo !== exp_lo) bad++;
    end
    chk("cut_quiet", bad, 0);
  endtask

  initial begin
    Reset = 1; Start = 0; Abort = 0; HiLoRead = 0;
    Op = '0; A = '0; B = '0;
    repeat (2) @(negedge Clk);
    Reset = 0;
    #1;
    chk("rst_hi", Hi, 0);
    chk("rst_lo", Lo, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);

    run_md(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
    @(negedge Clk);
    #1 chk("done_once", Done, 0);
    run_md(OP_MULT, 32'hFFFF_FFFD, 32'd7, -1, -1);
    run_md(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, -1);
    run_md(OP_DIVU, 32'h0000_1234, 32'd0, -1, -1);
    run_md(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    run_md(OP_DIV, 32'h8000_0005, 32'd0, -1, -1);
    @(negedge Clk);
    run_md(OP_MULT, 32'd6, 32'd7, 5, -1);
    @(negedge Clk);
    mt(OP_MTLO, 32'hDEAD_BEEF);
    run_md(OP_DIVU, $urandom, $urandom, -1, 10);
    @(negedge Clk);

    cut(OP_MULT, $urandom, $urandom, 12, 1'b1);
    mt(OP_MTHI, 32'h1234_5678);
    mt(OP_MTLO, 32'h9ABC_DEF0);
    cut(OP_MULT, $urandom, $urandom, 20, 1'b0);

    Start = 1; Op = OP_MULT; A = 32'd3; B = 32'd4; Abort = 1;
    @(negedge Clk);
    Start = 0; Abort = 0;
    #1 chk("idle_abort_busy", Busy, 0);
    Start = 1; Op = OP_MTHI; A = 32'h5555_AAAA; Abort = 1;
    @(negedge Clk);
    Start = 0; Abort = 0;
    #1 chk("idle_abort_mt", Hi, exp_hi);
    Start = 1; Op = 3'd6; A = 32'h1111_2222;
    @(negedge Clk);
    Start = 0;
    #1 chk("bad_op_busy", Busy, 0);
    chk("bad_op_hi", Hi, exp_hi);
    chk("bad_op_lo", Lo, exp_lo);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) @(negedge Clk);
      run_md(3'($urandom_range(0, 3)), pick(), pick(), -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
